// File: rtl/alu_pipe.sv
// Pipelined RV32I execute unit: STAGES-deep compute pipe feeding a credit-guarded result FIFO.
// Ports: clk/rst/rdy/flush control; in_* issue handshake; out_* CDB handshake; buf_count = FIFO occupancy.
module alu_pipe #(
  parameter int XLEN   = 32,
  parameter int ROBBW  = 4,
  parameter int STAGES = 2,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                in_code,
  input  logic [XLEN-1:0]           in_v1,
  input  logic [XLEN-1:0]           in_v2,
  input  logic [XLEN-1:0]           in_a,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [ROBBW-1:0]          in_rob_id,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROBBW-1:0]          out_rob_id,
  output logic [XLEN-1:0]           out_res,
  output logic [XLEN-1:0]           out_rel_pc,
  output logic                      out_taken,
  output logic [$clog2(QDEPTH):0]   buf_count
);

  localparam int SW = $clog2(XLEN);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int NP = STAGES - 1;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_SLL   = 6'd2;
  localparam logic [5:0] OP_SLT   = 6'd3;
  localparam logic [5:0] OP_SLTU  = 6'd4;
  localparam logic [5:0] OP_XOR   = 6'd5;
  localparam logic [5:0] OP_SRL   = 6'd6;
  localparam logic [5:0] OP_SRA   = 6'd7;
  localparam logic [5:0] OP_OR    = 6'd8;
  localparam logic [5:0] OP_AND   = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SLTI  = 6'd11;
  localparam logic [5:0] OP_SLTIU = 6'd12;
  localparam logic [5:0] OP_XORI  = 6'd13;
  localparam logic [5:0] OP_ORI   = 6'd14;
  localparam logic [5:0] OP_ANDI  = 6'd15;
  localparam logic [5:0] OP_SLLI  = 6'd16;
  localparam logic [5:0] OP_SRLI  = 6'd17;
  localparam logic [5:0] OP_SRAI  = 6'd18;
  localparam logic [5:0] OP_LUI   = 6'd19;
  localparam logic [5:0] OP_AUIPC = 6'd20;
  localparam logic [5:0] OP_BEQ   = 6'd21;
  localparam logic [5:0] OP_BNE   = 6'd22;
  localparam logic [5:0] OP_BLT   = 6'd23;
  localparam logic [5:0] OP_BGE   = 6'd24;
  localparam logic [5:0] OP_BLTU  = 6'd25;
  localparam logic [5:0] OP_BGEU  = 6'd26;
  localparam logic [5:0] OP_JAL   = 6'd27;
  localparam logic [5:0] OP_JALR  = 6'd28;

  typedef struct packed {
    logic [ROBBW-1:0] rob;
    logic [XLEN-1:0]  res;
    logic [XLEN-1:0]  rel;
    logic             tk;
  } ent_t;

  logic            imm;
  logic [XLEN-1:0] op2;
  logic [SW-1:0]   sh;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] pca;
  logic [XLEN-1:0] jt;
  logic            eq;
  logic            lt;
  logic            ltu;
  ent_t            c;

  always_comb begin
    imm   = (in_code >= OP_ADDI) && (in_code <= OP_SRAI);
    op2   = imm ? in_a : in_v2;
    sh    = op2[SW-1:0];
    pc4   = in_pc + XLEN'(4);
    pca   = in_pc + in_a;
    jt    = in_v1 + in_a;
    eq    = in_v1 == in_v2;
    lt    = $signed(in_v1) < $signed(in_v2);
    ltu   = in_v1 < in_v2;
    c     = '0;
    c.rob = in_rob_id;
    c.rel = pc4;
    case (in_code)
      OP_ADD, OP_ADDI:   c.res = in_v1 + op2;
      OP_SUB:            c.res = in_v1 - in_v2;
      OP_SLL, OP_SLLI:   c.res = in_v1 << sh;
      OP_SLT, OP_SLTI:   c.res = XLEN'($signed(in_v1) < $signed(op2));
      OP_SLTU, OP_SLTIU: c.res = XLEN'(in_v1 < op2);
      OP_XOR, OP_XORI:   c.res = in_v1 ^ op2;
      OP_SRL, OP_SRLI:   c.res = in_v1 >> sh;
      OP_SRA, OP_SRAI:   c.res = $unsigned($signed(in_v1) >>> sh);
      OP_OR, OP_ORI:     c.res = in_v1 | op2;
      OP_AND, OP_ANDI:   c.res = in_v1 & op2;
      OP_LUI:            c.res = in_a;
      OP_AUIPC:          c.res = pca;
      OP_BEQ:            c.tk  = eq;
      OP_BNE:            c.tk  = ~eq;
      OP_BLT:            c.tk  = lt;
      OP_BGE:            c.tk  = ~lt;
      OP_BLTU:           c.tk  = ltu;
      OP_BGEU:           c.tk  = ~ltu;
      OP_JAL: begin
        c.res = pc4;
        c.rel = pca;
        c.tk  = 1'b1;
      end
      OP_JALR: begin
        c.res = pc4;
        c.rel = jt & ~XLEN'(1);
        c.tk  = 1'b1;
      end
      default: ;
    endcase
    // Taken conditional branches redirect to pc+imm
    if (c.tk && in_code >= OP_BEQ && in_code <= OP_BGEU)
      c.rel = pca;
  end

  logic         acc;
  logic         wv;
  ent_t         wd;
  logic [CW:0]  inflight;
  logic [CW-1:0] count;
  logic         clr;

  assign clr = rst | flush;
  assign acc = in_valid & in_ready;

  generate
    if (NP > 0) begin : g_pipe
      logic [NP-1:0] pv;
      ent_t          pd [NP];

      always_ff @(posedge clk) begin
        if (clr) begin
          pv <= '0;
        end else if (rdy) begin
          pv[0] <= acc;
          pd[0] <= c;
          for (int i = 1; i < NP; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      always_comb begin
        inflight = '0;
        for (int i = 0; i < NP; i++)
          inflight = inflight + (CW+1)'(pv[i]);
      end

      assign wv = pv[NP-1];
      assign wd = pd[NP-1];
    end else begin : g_direct
      assign wv       = acc;
      assign wd       = c;
      assign inflight = '0;
    end
  endgenerate

  // Credit: reserve a FIFO slot for every op still in the pipe
  assign in_ready = rdy & ~rst & ~flush &
    (({1'b0, count} + inflight) < (CW+1)'(QDEPTH));

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  ent_t          mem [QDEPTH];
  logic          push;
  logic          pop;
  ent_t          hd;

  assign push = wv & rdy & ~clr;
  assign pop  = out_valid & out_ready & rdy & ~clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wd;
  end

  assign out_valid  = count != '0;
  assign hd         = out_valid ? mem[head] : '0;
  assign out_rob_id = hd.rob;
  assign out_res    = hd.res;
  assign out_rel_pc = hd.rel;
  assign out_taken  = hd.tk;
  assign buf_count  = count;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed RV32I cases, backpressure, flush, freeze, random traffic.
// Expected results come from a queue-based model that applies the opcode rules directly.
module tb_alu_pipe;

  localparam int STG = 2;
  localparam int QD  = 4;

  localparam int ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4;
  localparam int XOR_ = 5, SRL = 6, SRA = 7, OR_ = 8, AND_ = 9;
  localparam int ADDI = 10, SLTI = 11, SLTIU = 12, XORI = 13;
  localparam int ORI = 14, ANDI = 15, SLLI = 16, SRLI = 17, SRAI = 18;
  localparam int LUI = 19, AUIPC = 20, BEQ = 21, BNE = 22, BLT = 23;
  localparam int BGE = 24, BLTU = 25, BGEU = 26, JAL = 27, JALR = 28;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, in_ready;
  logic [5:0]  in_code;
  logic [31:0] in_v1, in_v2, in_a, in_pc;
  logic [3:0]  in_rob_id;
  logic        out_valid, out_ready;
  logic [3:0]  out_rob_id;
  logic [31:0] out_res, out_rel_pc;
  logic        out_taken;
  logic [2:0]  buf_count;

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(32), .ROBBW(4), .STAGES(STG), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_v1(in_v1), .in_v2(in_v2), .in_a(in_a), .in_pc(in_pc),
    .in_rob_id(in_rob_id), .out_valid(out_valid), .out_ready(out_ready),
    .out_rob_id(out_rob_id), .out_res(out_res), .out_rel_pc(out_rel_pc),
    .out_taken(out_taken), .buf_count(buf_count)
  );

  typedef struct {
    bit [3:0]  rob;
    bit [31:0] res;
    bit [31:0] rel;
    bit        tk;
  } exp_t;

  exp_t q[$];
  exp_t pq[$];
  int   pr[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_op(input int code, input bit [31:0] v1,
      input bit [31:0] v2, input bit [31:0] a, input bit [31:0] pc,
      input bit [3:0] rob);
    exp_t e;
    bit   cond;
    e.rob = rob;
    e.res = 0;
    e.rel = pc + 4;
    e.tk  = 0;
    cond  = 0;
    case (code)
      ADD:   e.res = v1 + v2;
      SUB:   e.res = v1 - v2;
      SLL:   e.res = v1 << v2[4:0];
      SLT:   e.res = ($signed(v1) < $signed(v2)) ? 1 : 0;
      SLTU:  e.res = (v1 < v2) ? 1 : 0;
      XOR_:  e.res = v1 ^ v2;
      SRL:   e.res = v1 >> v2[4:0];
      SRA:   e.res = $signed(v1) >>> v2[4:0];
      OR_:   e.res = v1 | v2;
      AND_:  e.res = v1 & v2;
      ADDI:  e.res = v1 + a;
      SLTI:  e.res = ($signed(v1) < $signed(a)) ? 1 : 0;
      SLTIU: e.res = (v1 < a) ? 1 : 0;
      XORI:  e.res = v1 ^ a;
      ORI:   e.res = v1 | a;
      ANDI:  e.res = v1 & a;
      SLLI:  e.res = v1 << a[4:0];
      SRLI:  e.res = v1 >> a[4:0];
      SRAI:  e.res = $signed(v1) >>> a[4:0];
      LUI:   e.res = a;
      AUIPC: e.res = pc + a;
      BEQ:   cond = (v1 == v2);
      BNE:   cond = (v1 != v2);
      BLT:   cond = ($signed(v1) < $signed(v2));
      BGE:   cond = ($signed(v1) >= $signed(v2));
      BLTU:  cond = (v1 < v2);
      BGEU:  cond = (v1 >= v2);
      JAL: begin
        e.res = pc + 4; e.rel = pc + a; e.tk = 1;
      end
      JALR: begin
        e.res = pc + 4; e.rel = (v1 + a) & 32'hFFFF_FFFE; e.tk = 1;
      end
      default: ;
    endcase
    if (cond) begin
      e.rel = pc + a;
      e.tk  = 1;
    end
    return e;
  endfunction

  function automatic bit exp_ready();
    return rdy && !rst && !flush && (q.size() + pq.size() < QD);
  endfunction

  task automatic check_outs();
    exp_t e;
    e = '{default: 0};
    if (q.size() != 0) e = q[0];
    chk("in_ready", in_ready, exp_ready());
    chk("buf_count", buf_count, q.size());
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_rob_id", out_rob_id, e.rob);
    chk("out_res", out_res, e.res);
    chk("out_rel_pc", out_rel_pc, e.rel);
    chk("out_taken", out_taken, e.tk);
  endtask

  task automatic tick();
    bit   acc, pop;
    exp_t e;
    #1;
    check_outs();
    acc = in_valid && exp_ready();
    pop = out_ready && q.size() != 0;
    e = ref_op(in_code, in_v1, in_v2, in_a, in_pc, in_rob_id);
    @(posedge clk);
    if (rst || flush) begin
      q.delete(); pq.delete(); pr.delete();
    end else if (rdy) begin
      if (pop) void'(q.pop_front());
      foreach (pr[i]) pr[i]--;
      while (pr.size() != 0 && pr[0] == 0) begin
        q.push_back(pq.pop_front());
        void'(pr.pop_front());
      end
      if (acc) begin
        if (STG == 1) q.push_back(e);
        else begin
          pq.push_back(e);
          pr.push_back(STG - 1);
        end
      end
    end
    #1;
  endtask

  task automatic drive(input int code, input bit [31:0] v1,
      input bit [31:0] v2, input bit [31:0] a, input bit [31:0] pc,
      input bit [3:0] rob);
    in_valid  = 1'b1;
    in_code   = 6'(code);
    in_v1     = v1;
    in_v2     = v2;
    in_a      = a;
    in_pc     = pc;
    in_rob_id = rob;
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 31), $urandom, $urandom, $urandom,
          $urandom & 32'hFFFF_FFFC, 4'($urandom));
  endtask

  task automatic directed(input string tag, input int code,
      input bit [31:0] v1, input bit [31:0] v2, input bit [31:0] a,
      input bit [31:0] pc, input bit [3:0] rob, input bit [31:0] eres,
      input bit [31:0] erel, input bit etk);
    drive(code, v1, v2, a, pc, rob);
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_rob"}, out_rob_id, rob);
    chk({tag, "_res"}, out_res, eres);
    chk({tag, "_rel"}, out_rel_pc, erel);
    chk({tag, "_taken"}, out_taken, etk);
    tick();
  endtask

  initial begin
    int sent;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_code = '0; in_v1 = '0; in_v2 = '0;
    in_a = '0; in_pc = '0; in_rob_id = '0;

    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    tick();
    chk("ready_after_rst", in_ready, 1);

    directed("addi", ADDI, 5, 0, 32'hFFFF_FFFD, 32'h10, 2, 2, 32'h14, 0);
    directed("blt", BLT, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 3,
             0, 32'h120, 1);
    directed("bltu", BLTU, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 4,
             0, 32'h104, 0);
    directed("jalr", JALR, 32'h1001, 0, 4, 32'h40, 5,
             32'h44, 32'h1004, 1);
    directed("sra", SRA, 32'h8000_0000, 31, 0, 32'h0, 6,
             32'hFFFF_FFFF, 32'h4, 0);
    directed("unk", 45, 7, 9, 11, 32'h200, 7, 0, 32'h204, 0);

    out_ready = 1'b0;
    sent = 0;
    drive_rand();
    for (int k = 0; k < 8; k++) begin
      if (in_valid && exp_ready()) begin
        tick(); sent++; drive_rand();
      end else tick();
    end
    chk("bp_sent", sent, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_count", buf_count, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 30 && sent < 6; k++) begin
      if (in_valid && exp_ready()) begin
        tick(); sent++;
        if (sent < 6) drive_rand(); else in_valid = 1'b0;
      end else tick();
    end
    chk("bp_total_sent", sent, 6);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && (q.size() + pq.size()) != 0; k++) tick();
    chk("bp_drained", q.size() + pq.size(), 0);
    tick();

    out_ready = 1'b0;
    for (int k = 0; k < 20 && !(q.size() == 3 && pq.size() == 1); k++) begin
      drive_rand();
      tick();
    end
    chk("pre_flush_count", buf_count, 3);
    flush = 1'b1;
    drive_rand();
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("post_flush_count", buf_count, 0);
    chk("post_flush_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_rand(); tick();
    end
    rdy = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_rand(); tick();
    end
    chk("frozen_count", buf_count, q.size());
    chk("frozen_ready", in_ready, 0);
    rdy = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    for (int k = 0; k < 400; k++) begin
      rdy       = $urandom_range(0, 9) != 0;
      flush     = $urandom_range(0, 29) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      drive_rand();
      in_valid  = $urandom_range(0, 3) != 0;
      tick();
    end
    rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && (q.size() + pq.size()) != 0; k++) tick();
    chk("final_drain", buf_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
